// File: rtl/sha3_theta_terms.sv
// Column-parity producer for Keccak theta: oterm[x] = XOR_y A[x][y], with the state and tag carried alongside.
// Latency 2 (OUTPUT_BUFFER=1) or 1 (OUTPUT_BUFFER=0); full valid/ready backpressure, holds up to 2 (or 1) beats.
module sha3_theta_terms #(
  parameter int OUTPUT_BUFFER = 1,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*25-1:0]       istate,
  input  logic [TAG_WIDTH-1:0]   itag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [64*5-1:0]        oterm,
  output logic [64*25-1:0]       ostate,
  output logic [TAG_WIDTH-1:0]   otag,
  output logic [1:0]             occupancy
);

  localparam int LANE_W = 64;
  localparam int NCOLS  = 5;

  logic                      s1_v_q, s1_v_d;
  logic [LANE_W*25-1:0]      s1_state_q, s1_state_d;
  logic [TAG_WIDTH-1:0]      s1_tag_q, s1_tag_d;
  logic [LANE_W*NCOLS-1:0]   s1_term;
  logic                      s1_drain;
  logic                      in_fire;

  // rstn gates in_ready so nothing is accepted while reset is asserted
  assign in_ready = rstn & (~s1_v_q | s1_drain);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_state_d = s1_state_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire) begin
      s1_v_d     = 1'b1;
      s1_state_d = istate;
      s1_tag_d   = itag;
    end else if (s1_drain) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) s1_v_q <= 1'b0;
    else       s1_v_q <= s1_v_d;
  end

  always_ff @(posedge clk) begin
    s1_state_q <= s1_state_d;
    s1_tag_q   <= s1_tag_d;
  end

  // lane A[x][y] sits at index x + 5*y; plain XOR, rotation is done downstream
  always_comb begin
    s1_term = '0;
    for (int x = 0; x < NCOLS; x++) begin
      for (int y = 0; y < 5; y++) begin
        s1_term[x*LANE_W +: LANE_W] = s1_term[x*LANE_W +: LANE_W]
                                    ^ s1_state_q[(x + NCOLS*y)*LANE_W +: LANE_W];
      end
    end
  end

  if (OUTPUT_BUFFER != 0) begin : g_obuf
    logic                    s2_v_q, s2_v_d, s2_load;
    logic [LANE_W*NCOLS-1:0] s2_term_q, s2_term_d;
    logic [LANE_W*25-1:0]    s2_state_q, s2_state_d;
    logic [TAG_WIDTH-1:0]    s2_tag_q, s2_tag_d;

    assign s2_load = s1_v_q & (~s2_v_q | out_ready);

    always_comb begin
      s2_v_d     = s2_v_q;
      s2_term_d  = s2_term_q;
      s2_state_d = s2_state_q;
      s2_tag_d   = s2_tag_q;
      if (s2_load) begin
        s2_v_d     = 1'b1;
        s2_term_d  = s1_term;
        s2_state_d = s1_state_q;
        s2_tag_d   = s1_tag_q;
      end else if (out_ready) begin
        s2_v_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) s2_v_q <= 1'b0;
      else       s2_v_q <= s2_v_d;
    end

    always_ff @(posedge clk) begin
      s2_term_q  <= s2_term_d;
      s2_state_q <= s2_state_d;
      s2_tag_q   <= s2_tag_d;
    end

    assign s1_drain  = s2_load;
    assign out_valid = s2_v_q;
    assign oterm     = s2_term_q;
    assign ostate    = s2_state_q;
    assign otag      = s2_tag_q;
    assign occupancy = {1'b0, s1_v_q} + {1'b0, s2_v_q};
  end else begin : g_comb
    assign s1_drain  = out_ready;
    assign out_valid = s1_v_q;
    assign oterm     = s1_term;
    assign ostate    = s1_state_q;
    assign otag      = s1_tag_q;
    assign occupancy = {1'b0, s1_v_q};
  end

endmodule

// File: tb/tb_sha3_theta_terms.sv
// Directed bench for sha3_theta_terms: one instance per OUTPUT_BUFFER setting, sharing the input drive.
module tb_sha3_theta_terms;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             out_ready;
  logic [1599:0]    istate;
  logic [7:0]       itag;

  logic             in_ready1, out_valid1, in_ready0, out_valid0;
  logic [319:0]     oterm1, oterm0;
  logic [1599:0]    ostate1, ostate0;
  logic [7:0]       otag1, otag0;
  logic [1:0]       occ1, occ0;

  logic             sel0;
  logic             ir, ov;
  logic [319:0]     oterm_s;
  logic [1599:0]    ostate_s;
  logic [7:0]       otag_s;
  logic [1:0]       occ_s;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [1599:0]    st [64];

  sha3_theta_terms #(.OUTPUT_BUFFER(1), .TAG_WIDTH(8)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1),
    .istate(istate), .itag(itag), .out_valid(out_valid1), .out_ready(out_ready),
    .oterm(oterm1), .ostate(ostate1), .otag(otag1), .occupancy(occ1)
  );

  sha3_theta_terms #(.OUTPUT_BUFFER(0), .TAG_WIDTH(8)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0),
    .istate(istate), .itag(itag), .out_valid(out_valid0), .out_ready(out_ready),
    .oterm(oterm0), .ostate(ostate0), .otag(otag0), .occupancy(occ0)
  );

  assign ir       = sel0 ? in_ready0  : in_ready1;
  assign ov       = sel0 ? out_valid0 : out_valid1;
  assign oterm_s  = sel0 ? oterm0     : oterm1;
  assign ostate_s = sel0 ? ostate0    : ostate1;
  assign otag_s   = sel0 ? otag0      : otag1;
  assign occ_s    = sel0 ? occ0       : occ1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [319:0] ref_par(input logic [1599:0] s);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[(i % 5)*64 +: 64] = r[(i % 5)*64 +: 64] ^ s[i*64 +: 64];
    return r;
  endfunction

  // Send nsend beats (tags tag0..) with out_ready=1 and expect nexp beats (tags etag0..) back-to-back.
  task automatic pump(input int nsend, input logic [7:0] tag0, input int nexp,
                      input logic [7:0] etag0, input string nm);
    int           sent = 0;
    int           rcv = 0;
    int           gaps = 0;
    logic [7:0]   t;
    logic [7:0]   et;
    logic [319:0] pr;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 64 && (rcv < nexp || sent < nsend); cyc++) begin
      t        = tag0 + 8'(sent);
      in_valid = (sent < nsend);
      itag     = t;
      istate   = st[int'(t[5:0])];
      #1;
      if (ov) begin
        et = etag0 + 8'(rcv);
        pr = ref_par(st[int'(et[5:0])]);
        chk({nm, "_tag"}, 64'(otag_s), 64'(et));
        for (int x = 0; x < 5; x++) chk({nm, "_term"}, oterm_s[x*64 +: 64], pr[x*64 +: 64]);
        chk({nm, "_state"}, 64'(ostate_s == st[int'(et[5:0])]), 64'd1);
        rcv++;
      end else if (rcv > 0 && rcv < nexp) begin
        gaps++;
      end
      if (in_valid && ir) sent++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk({nm, "_count"}, 64'(rcv), 64'(nexp));
    chk({nm, "_gaps"}, 64'(gaps), 64'd0);
    chk({nm, "_sent"}, 64'(sent), 64'(nsend));
    chk({nm, "_drained"}, 64'(ov), 64'd0);
  endtask

  logic [7:0]  hold_tag;
  logic [63:0] hold_t0;

  initial begin
    sel0      = 1'b0;
    rstn      = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    itag      = 8'h00;
    istate    = '0;
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < 50; i++) st[k][i*32 +: 32] = $urandom;
    for (int i = 0; i < 25; i++) st[26][i*64 +: 64] = 64'h1 << i;

    // reset held 3 cycles with in_valid asserted
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_in_ready", 64'(in_ready1), 64'd0);
      chk("rst_out_valid", 64'(out_valid1), 64'd0);
      chk("rst_occ", 64'(occ1), 64'd0);
    end
    rstn = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rel_in_ready", 64'(in_ready1), 64'd1);

    // single beat, OUTPUT_BUFFER=1
    istate = st[26];
    itag = 8'h5A;
    in_valid = 1'b1;
    #1;
    chk("sb1_in_ready", 64'(in_ready1), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sb1_lat1_valid", 64'(out_valid1), 64'd0);
    tick();
    chk("sb1_valid", 64'(out_valid1), 64'd1);
    chk("sb1_tag", 64'(otag1), 64'h5A);
    chk("sb1_t0", oterm1[0*64 +: 64], 64'h108421);
    chk("sb1_t1", oterm1[1*64 +: 64], 64'h210842);
    chk("sb1_t2", oterm1[2*64 +: 64], 64'h421084);
    chk("sb1_t3", oterm1[3*64 +: 64], 64'h842108);
    chk("sb1_t4", oterm1[4*64 +: 64], 64'h1084210);
    chk("sb1_state", 64'(ostate1 == st[26]), 64'd1);
    tick();
    chk("sb1_after_valid", 64'(out_valid1), 64'd0);
    chk("sb1_after_occ", 64'(occ1), 64'd0);

    // streaming
    pump(16, 8'h00, 16, 8'h00, "stream");

    // backpressure, OUTPUT_BUFFER=1
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      itag = 8'h10 + 8'(b);
      istate = st[16 + b];
      #1;
      chk("bp1_accept", 64'(in_ready1), 64'd1);
      tick();
    end
    itag = 8'h12;
    istate = st[18];
    #1;
    chk("bp1_full_ready", 64'(in_ready1), 64'd0);
    chk("bp1_occ", 64'(occ1), 64'd2);
    chk("bp1_valid", 64'(out_valid1), 64'd1);
    chk("bp1_tag", 64'(otag1), 64'h10);
    hold_tag = otag1;
    hold_t0 = oterm1[63:0];
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("bp1_hold_ready", 64'(in_ready1), 64'd0);
      chk("bp1_hold_valid", 64'(out_valid1), 64'd1);
      chk("bp1_hold_tag", 64'(otag1), 64'(hold_tag));
      chk("bp1_hold_term", oterm1[63:0], hold_t0);
      chk("bp1_hold_occ", 64'(occ1), 64'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp1_full_shift_ready", 64'(in_ready1), 64'd1);
    pump(1, 8'h12, 3, 8'h10, "bp1_drain");

    // reset mid-flight
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      itag = 8'h20 + 8'(b);
      istate = st[32 + b];
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("mrst_occ_before", 64'(occ1), 64'd2);
    rstn = 1'b0;
    tick();
    chk("mrst_valid", 64'(out_valid1), 64'd0);
    chk("mrst_occ", 64'(occ1), 64'd0);
    rstn = 1'b1;
    pump(1, 8'h22, 1, 8'h22, "mrst_next");

    // OUTPUT_BUFFER=0 instance
    sel0 = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    out_ready = 1'b1;
    istate = st[26];
    itag = 8'h5A;
    in_valid = 1'b1;
    #1;
    chk("sb0_in_ready", 64'(in_ready0), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sb0_valid", 64'(out_valid0), 64'd1);
    chk("sb0_tag", 64'(otag0), 64'h5A);
    chk("sb0_t0", oterm0[0*64 +: 64], 64'h108421);
    chk("sb0_t4", oterm0[4*64 +: 64], 64'h1084210);
    chk("sb0_occ", 64'(occ0), 64'd1);
    tick();
    chk("sb0_after_valid", 64'(out_valid0), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    itag = 8'h30;
    istate = st[48];
    #1;
    chk("bp0_accept", 64'(in_ready0), 64'd1);
    tick();
    itag = 8'h31;
    istate = st[49];
    #1;
    chk("bp0_full_ready", 64'(in_ready0), 64'd0);
    chk("bp0_occ", 64'(occ0), 64'd1);
    chk("bp0_valid", 64'(out_valid0), 64'd1);
    chk("bp0_tag", 64'(otag0), 64'h30);
    tick();
    chk("bp0_hold_ready", 64'(in_ready0), 64'd0);
    chk("bp0_hold_tag", 64'(otag0), 64'h30);
    out_ready = 1'b1;
    #1;
    chk("bp0_shift_ready", 64'(in_ready0), 64'd1);
    pump(1, 8'h31, 2, 8'h30, "bp0_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
